// File: rtl/k2_exec_pkg.sv
// Shared types and constants for the program-bank K2 execution top.
package k2_exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } exec_state_t;

    localparam logic CAPTURE_CHANGE = 1'b0;
    localparam logic CAPTURE_EVERY  = 1'b1;

    localparam int INST_W  = 8;
    localparam int PADDR_W = 4;

endpackage

// File: rtl/K2_processor_withMem.sv
// K2 core: Ra/Rb/Ro registers, carry flag, 16-entry program counter.
// Encoding: I[7]=1 jump (I[6]=1 only if carry) to I[3:0]; else dest I[5:4] <= I[3] ? imm I[2:0] : Ra+Rb.
module K2_processor_withMem
    import k2_exec_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INST_W-1:0]  Instruction,
    output logic [PADDR_W-1:0] ProgramAddress,
    output logic [BITS-1:0]    Ro
);

    localparam logic [PADDR_W-1:0] PC_ONE = PADDR_W'(1);

    logic [PADDR_W-1:0] pc_q, pc_d;
    logic [BITS-1:0]    ra_q, ra_d, rb_q, rb_d, ro_q, ro_d;
    logic               carry_q, carry_d;
    logic [BITS:0]      sum;
    logic [BITS-1:0]    imm;
    logic [BITS-1:0]    operand;

    always_comb begin
        sum     = {1'b0, ra_q} + {1'b0, rb_q};
        imm     = {{(BITS-3){1'b0}}, Instruction[2:0]};
        operand = Instruction[3] ? imm : sum[BITS-1:0];
        pc_d    = pc_q + PC_ONE;
        ra_d    = ra_q;
        rb_d    = rb_q;
        ro_d    = ro_q;
        carry_d = carry_q;
        if (Instruction[7]) begin
            if (!Instruction[6] || carry_q) begin
                pc_d = Instruction[PADDR_W-1:0];
            end
        end else begin
            // Only additions touch the carry flag; immediates leave it alone.
            if (!Instruction[3]) begin
                carry_d = sum[BITS];
            end
            case (Instruction[5:4])
                2'b00:   ra_d = operand;
                2'b01:   rb_d = operand;
                2'b10:   ro_d = operand;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            ro_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            ro_q    <= ro_d;
            carry_q <= carry_d;
        end
    end

    assign ProgramAddress = pc_q;
    assign Ro             = ro_q;

endmodule

// File: rtl/exec_result_fifo.sv
// Result FIFO with a registered head word; flush empties it in one cycle.
module exec_result_fifo #(
    parameter int BITS       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  logic [BITS-1:0] push_data,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [BITS-1:0] head_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

    logic [BITS-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [BITS-1:0]  head_q, head_d;
    logic             pop_ok, push_ok;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty & ~flush;
    // A pop frees the slot this cycle, so a push into a full FIFO still fits.
    assign push_ok = push & (~full | pop_ok) & ~flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (count_d == '0) begin
                head_d = '0;
            end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_data = head_q;

endmodule

// File: rtl/program_bank_executor.sv
// K2 core running from one of NUM_PROGRAMS writable instruction banks under a
// run/stop/budget FSM; Ro samples stream out through a valid/ready FIFO.
module program_bank_executor
    import k2_exec_pkg::*;
#(
    parameter int BITS         = 8,
    parameter int NUM_PROGRAMS = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int CYC_BITS     = 16,
    localparam int SEL_W       = (NUM_PROGRAMS > 1) ? $clog2(NUM_PROGRAMS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_bank,
    input  logic [3:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                start,
    input  logic                stop,
    input  logic [SEL_W-1:0]    prog_sel,
    input  logic                capture_mode,
    input  logic [CYC_BITS-1:0] max_cycles,
    output logic                busy,
    output logic                done,
    output logic [CYC_BITS-1:0] cycle_count,
    output logic [BITS-1:0]     out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overflow
);

    localparam logic [SEL_W:0]    NUM_SEL = (SEL_W+1)'(NUM_PROGRAMS);
    localparam logic [CYC_BITS-1:0] CYC_ONE = CYC_BITS'(1);
    localparam logic [CYC_BITS-1:0] CYC_MAX = '1;

    exec_state_t         state_q, state_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                core_rst_n_q, core_rst_n_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                mode_q, mode_d;
    logic [CYC_BITS-1:0] max_q, max_d;
    logic [CYC_BITS-1:0] cycle_count_q, cycle_count_d;
    logic                overflow_q, overflow_d;
    logic                first_q, first_d;
    logic [BITS-1:0]     last_q, last_d;

    logic [INST_W-1:0]   bank_q [NUM_PROGRAMS][1 << PADDR_W];
    logic                bank_we;
    logic [INST_W-1:0]   core_inst;
    logic [PADDR_W-1:0]  core_pa;
    logic [BITS-1:0]     core_ro;

    logic                fifo_flush, fifo_full, fifo_empty;
    logic                push_req, push_taken, end_run;

    assign bank_we = wr_en & ~busy_q & ({1'b0, wr_bank} < NUM_SEL);

    always_ff @(posedge clk) begin
        if (bank_we) begin
            bank_q[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Fetch is combinational so the core sees its instruction in the same cycle.
    assign core_inst = ({1'b0, sel_q} < NUM_SEL) ? bank_q[sel_q][core_pa] : '0;

    K2_processor_withMem #(
        .BITS(BITS)
    ) u_core (
        .clk           (clk),
        .rst_n         (core_rst_n_q),
        .Instruction   (core_inst),
        .ProgramAddress(core_pa),
        .Ro            (core_ro)
    );

    assign push_req   = (state_q == RUN) &&
                        ((mode_q == CAPTURE_EVERY) || first_q || (core_ro != last_q));
    assign push_taken = push_req & (~fifo_full | (out_ready & ~fifo_empty));
    assign end_run    = stop ||
                        ((max_q != '0) && (cycle_count_q == max_q - CYC_ONE)) ||
                        ((max_q == '0) && (cycle_count_q == CYC_MAX - CYC_ONE));

    exec_result_fifo #(
        .BITS      (BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (fifo_flush),
        .push     (push_req),
        .push_data(core_ro),
        .pop      (out_ready),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_data(out_data)
    );

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = done_q;
        core_rst_n_d  = core_rst_n_q;
        sel_d         = sel_q;
        mode_d        = mode_q;
        max_d         = max_q;
        cycle_count_d = cycle_count_q;
        overflow_d    = overflow_q;
        first_d       = first_q;
        last_d        = last_q;
        fifo_flush    = 1'b0;
        case (state_q)
            RUN: begin
                cycle_count_d = (cycle_count_q == CYC_MAX) ? CYC_MAX : cycle_count_q + CYC_ONE;
                // A dropped sample leaves last_q alone so the change is retried.
                if (push_req) begin
                    if (push_taken) begin
                        last_d  = core_ro;
                        first_d = 1'b0;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (end_run) begin
                    state_d      = DONE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    core_rst_n_d = 1'b0;
                end
            end
            default: begin
                if (start) begin
                    state_d       = RUN;
                    busy_d        = 1'b1;
                    done_d        = 1'b0;
                    core_rst_n_d  = 1'b1;
                    sel_d         = prog_sel;
                    mode_d        = capture_mode;
                    max_d         = max_cycles;
                    cycle_count_d = '0;
                    overflow_d    = 1'b0;
                    first_d       = 1'b1;
                    fifo_flush    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            core_rst_n_q  <= 1'b0;
            sel_q         <= '0;
            mode_q        <= CAPTURE_CHANGE;
            max_q         <= '0;
            cycle_count_q <= '0;
            overflow_q    <= 1'b0;
            first_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            core_rst_n_q  <= core_rst_n_d;
            sel_q         <= sel_d;
            mode_q        <= mode_d;
            max_q         <= max_d;
            cycle_count_q <= cycle_count_d;
            overflow_q    <= overflow_d;
            first_q       <= first_d;
        end
    end

    always_ff @(posedge clk) begin
        last_q <= last_d;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = cycle_count_q;
    assign overflow    = overflow_q;
    assign out_valid   = ~fifo_empty;

endmodule

// File: tb/tb_program_bank_executor.sv
// Directed bench for program_bank_executor using a Fibonacci image.
module tb_program_bank_executor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_bank = '0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  prog_sel = '0;
    logic        capture_mode = 1'b0;
    logic [15:0] max_cycles = '0;
    logic        busy, done, out_valid, overflow;
    logic [15:0] cycle_count;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] got[$];
    bit         collect_to;

    // Ra=0, Rb=1; loop: Ro=Ra+Rb, Ra+=Rb, JC 9, Ro=Ra+Rb, Rb+=Ra, JC 9, J 2; 9: J 9
    logic [7:0] fib_img [16] = '{8'h08, 8'h19, 8'h20, 8'h00, 8'hC9, 8'h20, 8'h10, 8'hC9,
                                 8'h82, 8'h89, 8'h89, 8'h89, 8'h89, 8'h89, 8'h89, 8'h89};
    logic [7:0] fib_exp [14] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21,
                                 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};

    program_bank_executor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .stop        (stop),
        .prog_sel    (prog_sel),
        .capture_mode(capture_mode),
        .max_cycles  (max_cycles),
        .busy        (busy),
        .done        (done),
        .cycle_count (cycle_count),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic load_bank(input logic [1:0] b);
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_bank = b; wr_addr = i[3:0]; wr_data = fib_img[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge inside the first RUN cycle.
    task automatic start_run(input logic [1:0] sel, input logic mode, input logic [15:0] maxc);
        prog_sel = sel; capture_mode = mode; max_cycles = maxc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input int budget, input bit corrupt);
        int n;
        n = 0;
        got.delete();
        collect_to = 1'b0;
        while ((busy || out_valid) && n < budget) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (corrupt && busy) begin
                wr_en = 1'b1; wr_bank = 2'd0; wr_addr = n[3:0]; wr_data = 8'h89;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        wr_en = 1'b0;
        if (n >= budget) collect_to = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n); end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (cycle_count !== 16'd0) begin miscompares++; $display("FAIL reset_cycles got=%0d exp=0", cycle_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        vectors++; if (out_data !== 8'd0) begin miscompares++; $display("FAIL reset_data got=%0d exp=0", out_data); end
    endtask

    task automatic test_budget();
        int cnt;
        out_ready = 1'b1;
        start_run(2'd1, 1'b0, 16'd5);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL budget_busy got=%b exp=1", busy); end
        vectors++; if (cycle_count !== 16'd0) begin miscompares++; $display("FAIL budget_count0 got=%0d exp=0", cycle_count); end
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
        vectors++; if (cnt != 5) begin miscompares++; $display("FAIL budget_busy_cycles got=%0d exp=5", cnt); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL budget_done got=%b exp=1", done); end
        vectors++; if (cycle_count !== 16'd5) begin miscompares++; $display("FAIL budget_count got=%0d exp=5", cycle_count); end
    endtask

    task automatic test_fib_stream();
        load_bank(2'd2);
        out_ready = 1'b1;
        start_run(2'd2, 1'b0, 16'd200);
        collect(400, 1'b0);
        vectors++; if (collect_to) begin miscompares++; $display("FAIL fib_timeout got=timeout exp=finish"); end
        vectors++; if (got.size() != 14) begin miscompares++; $display("FAIL fib_len got=%0d exp=14", got.size()); end
        for (int i = 0; i < 14; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== fib_exp[i]) begin
                miscompares++;
                $display("FAIL fib_val[%0d] got=%0d exp=%0d", i, (i < got.size()) ? got[i] : 8'hxx, fib_exp[i]);
            end
        end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fib_overflow got=%b exp=0", overflow); end
        vectors++; if (cycle_count !== 16'd200) begin miscompares++; $display("FAIL fib_count got=%0d exp=200", cycle_count); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        start_run(2'd2, 1'b0, 16'd200);
        wait_done(300);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid got=%b exp=1", out_valid); end
        out_ready = 1'b1;
        collect(20, 1'b0);
        vectors++; if (got.size() != 8) begin miscompares++; $display("FAIL ovf_len got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= got.size() || got[i] !== fib_exp[i]) begin
                miscompares++;
                $display("FAIL ovf_val[%0d] got=%0d exp=%0d", i, (i < got.size()) ? got[i] : 8'hxx, fib_exp[i]);
            end
        end
    endtask

    task automatic test_stop();
        out_ready = 1'b0;
        start_run(2'd2, 1'b1, 16'd0);
        repeat (9) @(negedge clk);
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stop_done got=%b exp=1", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy got=%b exp=0", busy); end
        vectors++; if (cycle_count !== 16'd10) begin miscompares++; $display("FAIL stop_count got=%0d exp=10", cycle_count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL stop_overflow got=%b exp=1", overflow); end
        vectors++; if (out_data !== 8'd0) begin miscompares++; $display("FAIL stop_head got=%0d exp=0", out_data); end
        stop = 1'b1;
        repeat (3) @(negedge clk);
        stop = 1'b0;
        vectors++; if (done !== 1'b1 || cycle_count !== 16'd10) begin miscompares++; $display("FAIL stop_hold got=%b/%0d exp=1/10", done, cycle_count); end
        start_run(2'd2, 1'b0, 16'd3);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rearm_busy got=%b exp=1", busy); end
        vectors++; if (cycle_count !== 16'd0) begin miscompares++; $display("FAIL rearm_count got=%0d exp=0", cycle_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rearm_overflow got=%b exp=0", overflow); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rearm_valid got=%b exp=0", out_valid); end
        wait_done(10);
        vectors++; if (cycle_count !== 16'd3) begin miscompares++; $display("FAIL rearm_final got=%0d exp=3", cycle_count); end
    endtask

    task automatic test_back_to_back();
        load_bank(2'd0);
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            start_run(2'd0, 1'b0, 16'd200);
            collect(400, (r == 0));
            vectors++; if (got.size() != 14) begin miscompares++; $display("FAIL b2b_len[%0d] got=%0d exp=14", r, got.size()); end
            for (int i = 0; i < 14; i++) begin
                vectors++;
                if (i >= got.size() || got[i] !== fib_exp[i]) begin
                    miscompares++;
                    $display("FAIL b2b_val[%0d][%0d] got=%0d exp=%0d", r, i, (i < got.size()) ? got[i] : 8'hxx, fib_exp[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        start_run(2'd2, 1'b1, 16'd0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy got=%b exp=0", busy); end
        vectors++; if (cycle_count !== 16'd0) begin miscompares++; $display("FAIL areset_count got=%0d exp=0", cycle_count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
        vectors++; if (dut.core_rst_n_q !== 1'b0) begin miscompares++; $display("FAIL areset_core got=%b exp=0", dut.core_rst_n_q); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL areset_idle got=%b/%b exp=0/0", busy, done); end
        vectors++; if (dut.core_rst_n_q !== 1'b0) begin miscompares++; $display("FAIL areset_core_hold got=%b exp=0", dut.core_rst_n_q); end
        vectors++; if (cycle_count !== 16'd0) begin miscompares++; $display("FAIL areset_count_hold got=%0d exp=0", cycle_count); end
        start_run(2'd2, 1'b0, 16'd5);
        vectors++; if (busy !== 1'b1 || dut.core_rst_n_q !== 1'b1) begin miscompares++; $display("FAIL areset_restart got=%b/%b exp=1/1", busy, dut.core_rst_n_q); end
        wait_done(10);
    endtask

    initial begin
        test_reset();
        test_budget();
        test_fib_stream();
        test_overflow();
        test_stop();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_bank_executor.md
Name: program_bank_executor

Overview:
- Parametrised successor to the fixed-program K2 execution tops.
- Wraps one K2_processor_withMem with NUM_PROGRAMS writable 16x8 instruction banks, and selects the bank at run start.
- A run/stop/budget FSM controls execution. The core is held in reset when idle.
- Ro samples are captured into a valid/ready output FIFO. Overflow is flagged, because the core cannot stall.

Parameters:
BITS, 8, datapath width passed to K2_processor_withMem and width of out_data
NUM_PROGRAMS, 4, number of 16-entry instruction banks (>=1)
FIFO_DEPTH, 8, output FIFO entries (power of two, >=2)
CYC_BITS, 16, width of cycle budget and cycle counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  bank write strobe; ignored while busy
wr_bank  in  max(1,$clog2(NUM_PROGRAMS))  bank to write
wr_addr  in  4  instruction address
wr_data  in  8  instruction byte
start  in  1  begin run (IDLE/DONE only)
stop  in  1  abort run
prog_sel  in  max(1,$clog2(NUM_PROGRAMS))  bank executed, latched at start
capture_mode  in  1  0: push on Ro change; 1: push every run cycle; latched at start
max_cycles  in  CYC_BITS  run budget in cycles; 0 means unlimited; latched at start
busy  out  1  high in RUN
done  out  1  high in DONE
cycle_count  out  CYC_BITS  cycles executed in current/last run
out_data  out  BITS  FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when out_valid & out_ready
overflow  out  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, core reset asserted.
  - busy=0, done=0, cycle_count=0, overflow=0, FIFO empty (out_valid=0, out_data=0).
  - Bank contents are not reset; they are undefined until written.
- Core reset:
  - core_rst_n is a register, cleared asynchronously by rst_n.
  - It is set synchronously on the start edge and cleared synchronously on leaving RUN.
  - The core sees rst_n low whenever the block is not in RUN.
- Bank memory:
  - Synchronous write at clk when wr_en & !busy.
  - wr_bank >= NUM_PROGRAMS is ignored.
  - Instruction fetch is combinational: bank[sel_q][ProgramAddress], identical timing to the fixed-ROM tops.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE, start=1:
    - Latch prog_sel, capture_mode, max_cycles.
    - Clear cycle_count, overflow and the FIFO.
    - Go to RUN; busy=1 from the next cycle.
  - RUN: cycle_count increments each cycle, saturating at all-ones.
  - RUN -> DONE when any of these holds:
    - stop=1;
    - max_cycles != 0 and cycle_count == max_cycles-1 at the clock edge (exactly max_cycles run cycles executed);
    - cycle_count saturates while the budget is unlimited.
  - DONE holds done=1 and keeps the FIFO and cycle_count readable. start re-arms; stop is ignored.
  - start and stop in the same cycle:
    - In RUN, stop wins (start is ignored).
    - In IDLE/DONE, start wins.
- Capture, RUN cycles only, sampling Ro after the core's clock edge:
  - Mode 1 pushes every cycle.
  - Mode 0 pushes when Ro != last pushed value. The first RUN cycle always pushes.
- FIFO:
  - Push when full: the sample is dropped, overflow=1 (sticky until the next start or reset), last-pushed value is not updated.
  - Simultaneous push and pop when full: both succeed.
  - Pops are allowed in any state.
  - out_data is the registered head; out_valid=1 within one cycle of the first push.
- Reset mid-run: immediate IDLE, all outputs at reset values, core reset asserted.
- Arithmetic: Ro and the FIFO are BITS wide, with no sign handling. The counter is unsigned and saturating.

Decomposition:
- Package k2_exec_pkg holds:
  - exec_state_t enum {IDLE, RUN, DONE};
  - CAPTURE_CHANGE=1'b0, CAPTURE_EVERY=1'b1;
  - INST_W=8, PADDR_W=4.
- One sub-module: exec_result_fifo (parametrised BITS, FIFO_DEPTH; push, pop, full, empty, registered head).
- Banks and the FSM live in the top.

Test Plan:
- Reset then idle: all outputs are 0. A start with an unwritten bank still asserts busy next cycle. With max_cycles=5, done=1 after exactly 5 busy cycles and cycle_count=5.
- Load the codebase Fibonacci program image into bank 2. Run prog_sel=2, capture_mode=0, max_cycles=200, out_ready=1. The out stream is 0,1,2,3,5,8,13,21,34,55,89,144,233,121(=377 mod 256), and overflow=0.
- Same run with out_ready=0 and FIFO_DEPTH=8: the first 8 samples are retained in order, then overflow=1. Raising out_ready afterwards drains exactly those 8 values.
- stop asserted on RUN cycle 10, with start also high that cycle: DONE next cycle, cycle_count=10, start ignored. A later start re-clears overflow, the FIFO and cycle_count.
- wr_en to bank 0 while busy: no change. Repeating a run of bank 0 yields an identical out stream.
- rst_n pulled low mid-run for 1 cycle (asynchronous, between clock edges): outputs clear immediately, state=IDLE, the core stays in reset until the next start.
